// File: rtl/pe_acc_unit.sv
// pe_acc_unit: windowed signed accumulator behind a PE multiplier; result valid 1 cycle after the last product, held until i_acc_rdy.
// Optional build macro ACC_SAT_EN: saturate the accumulator on overflow instead of wrapping.
module pe_acc_unit #(
  parameter int M_BW   = 16,
  parameter int ACC_BW = 24,
  parameter int CNT_BW = 5
) (
  input  logic                     en_clk,
  input  logic                     rst_n,
  input  logic                     i_start,
  input  logic [CNT_BW-1:0]        i_k_len,
  input  logic                     i_mul_vld,
  input  logic signed [M_BW-1:0]   i_mul,
  input  logic                     i_acc_rdy,
  output logic                     o_acc_vld,
  output logic signed [ACC_BW-1:0] o_acc,
  output logic                     o_ovf,
  output logic                     o_busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam logic signed [ACC_BW-1:0] ACC_MAX = {1'b0, {(ACC_BW-1){1'b1}}};
  localparam logic signed [ACC_BW-1:0] ACC_MIN = {1'b1, {(ACC_BW-1){1'b0}}};

  state_t                    state, state_nxt;
  logic signed [ACC_BW-1:0]  acc, acc_nxt, mul_ext, sum;
  logic [CNT_BW-1:0]         cnt, cnt_nxt, len, len_nxt, len_eff;
  logic                      ovf, ovf_nxt, add_ovf, open_win;

  assign mul_ext = ACC_BW'(i_mul);
  assign sum     = acc + mul_ext;
  // Signed overflow: operands agree in sign but the truncated sum does not.
  assign add_ovf = (acc[ACC_BW-1] == mul_ext[ACC_BW-1]) && (sum[ACC_BW-1] != acc[ACC_BW-1]);
  assign len_eff = (len == '0) ? CNT_BW'(1) : len;
  assign open_win = i_start && ((state == IDLE) || ((state == HOLD) && i_acc_rdy));

  always_ff @(posedge en_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      len   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      len   <= len_nxt;
      ovf   <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    len_nxt   = len;
    ovf_nxt   = ovf;
    o_acc_vld = 1'b0;
    o_busy    = 1'b0;
    o_acc     = acc;
    o_ovf     = ovf;

    case (state)
      IDLE: ;
      ACCUM: begin
        o_busy = 1'b1;
        if (i_mul_vld) begin
          cnt_nxt = cnt + CNT_BW'(1);
          acc_nxt = sum;
          if (add_ovf) begin
            ovf_nxt = 1'b1;
`ifdef ACC_SAT_EN
            acc_nxt = acc[ACC_BW-1] ? ACC_MIN : ACC_MAX;
`else
            acc_nxt = sum;
`endif
          end
          if (cnt_nxt == len_eff) state_nxt = HOLD;
        end
      end
      HOLD: begin
        o_acc_vld = 1'b1;
        if (i_acc_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // Opening a window from HOLD skips IDLE so back-to-back windows see no bubble.
    if (open_win) begin
      state_nxt = ACCUM;
      len_nxt   = i_k_len;
      acc_nxt   = '0;
      cnt_nxt   = '0;
      ovf_nxt   = 1'b0;
    end
  end

endmodule

// File: tb/tb_pe_acc_unit.sv
// Bench for pe_acc_unit: 24-bit and 16-bit accumulator instances share stimulus, checked against an arithmetic window model.
module tb_pe_acc_unit;

  logic        en_clk, rst_n, i_start, i_mul_vld, i_acc_rdy;
  logic [4:0]  i_k_len;
  logic [15:0] i_mul;

  logic               vld24, ovf24, busy24;
  logic signed [23:0] acc24;
  logic               vld16, ovf16, busy16;
  logic signed [15:0] acc16;

  int n_chk  = 0;
  int n_fail = 0;
  int win_q[$];
  longint e24, e16;
  bit     f24, f16;

  pe_acc_unit #(.M_BW(16), .ACC_BW(24), .CNT_BW(5)) dut24 (
    .en_clk(en_clk), .rst_n(rst_n), .i_start(i_start), .i_k_len(i_k_len),
    .i_mul_vld(i_mul_vld), .i_mul(i_mul), .i_acc_rdy(i_acc_rdy),
    .o_acc_vld(vld24), .o_acc(acc24), .o_ovf(ovf24), .o_busy(busy24));

  pe_acc_unit #(.M_BW(16), .ACC_BW(16), .CNT_BW(5)) dut16 (
    .en_clk(en_clk), .rst_n(rst_n), .i_start(i_start), .i_k_len(i_k_len),
    .i_mul_vld(i_mul_vld), .i_mul(i_mul), .i_acc_rdy(i_acc_rdy),
    .o_acc_vld(vld16), .o_acc(acc16), .o_ovf(ovf16), .o_busy(busy16));

  initial begin
    en_clk = 1'b0;
    forever #5 en_clk = ~en_clk;
  end

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge en_clk);
    #1;
  endtask

  // Window result from plain integer sums: each add checked against the w-bit signed range.
  function automatic void model(input int w, output longint r, output bit f);
    longint mx, mn, t;
    mx = (longint'(1) <<< (w - 1)) - 1;
    mn = -mx - 1;
    r = 0;
    f = 1'b0;
    foreach (win_q[i]) begin
      t = r + win_q[i];
      if (t > mx || t < mn) begin
        f = 1'b1;
`ifdef ACC_SAT_EN
        t = (t > mx) ? mx : mn;
`else
        t = (t > mx) ? t - 2 * (mx + 1) : t + 2 * (mx + 1);
`endif
      end
      r = t;
    end
  endfunction

  // Opens a window (optionally as the handshake cycle of a held result) and feeds win_q.
  task automatic feed(input int k, input int mask, input bit b2b);
    int eff;
    eff = (k == 0) ? 1 : k;
    i_start = 1'b1; i_k_len = 5'(k); i_acc_rdy = b2b;
    i_mul_vld = 1'b1; i_mul = 16'($urandom);
    step();
    i_start = 1'b0; i_acc_rdy = 1'b0;
    check_eq("busy_open", busy24, 1);
    for (int i = 0; i < eff; i++) begin
      if (mask[i]) begin
        i_mul_vld = 1'b0; i_mul = 16'($urandom);
        i_start = 1'b1; i_k_len = 5'($urandom);
        step();
        i_start = 1'b0;
      end
      i_mul_vld = 1'b1; i_mul = 16'(win_q[i]);
      if (i == eff - 1) check_eq("vld_pre_last", vld24, 0);
      step();
    end
    i_mul_vld = 1'b0;
    model(24, e24, f24);
    model(16, e16, f16);
    check_eq("vld24", vld24, 1);
    check_eq("busy_hold", busy24, 0);
    check_eq("acc24", acc24, e24);
    check_eq("ovf24", ovf24, f24);
    check_eq("vld16", vld16, 1);
    check_eq("acc16", acc16, e16);
    check_eq("ovf16", ovf16, f16);
  endtask

  task automatic hold(input int n);
    i_acc_rdy = 1'b0;
    for (int i = 0; i < n; i++) begin
      i_mul_vld = 1'b1; i_mul = 16'($urandom);
      step();
      check_eq("hold_vld", vld24, 1);
      check_eq("hold_acc24", acc24, e24);
      check_eq("hold_ovf16", ovf16, f16);
    end
    i_mul_vld = 1'b0;
  endtask

  task automatic release_result();
    i_acc_rdy = 1'b1; i_mul_vld = 1'b1; i_mul = 16'($urandom);
    step();
    i_acc_rdy = 1'b0; i_mul_vld = 1'b0;
    check_eq("rel_vld", vld24, 0);
    check_eq("rel_busy", busy24, 0);
  endtask

  initial begin
    int k, eff, mask;
    rst_n = 1'b0; i_start = 1'b0; i_k_len = '0; i_mul_vld = 1'b0; i_mul = '0; i_acc_rdy = 1'b0;
    step();
    step();
    check_eq("rst_vld", vld24, 0);
    check_eq("rst_acc", acc24, 0);
    check_eq("rst_ovf", ovf24, 0);
    check_eq("rst_busy", busy24, 0);
    rst_n = 1'b1;
    step();

    win_q = '{100, -20, 5};
    feed(3, 0, 1'b0);
    release_result();

    win_q = '{7, 7, 7, 7};
    feed(4, 'b0110, 1'b0);
    release_result();

    win_q = '{1000, 2000};
    feed(2, 0, 1'b0);
    hold(5);
    win_q = '{-1};
    feed(1, 0, 1'b1);
    release_result();

    win_q = '{32767};
    feed(0, 1, 1'b0);
    release_result();

    win_q = {};
    for (int i = 0; i < 31; i++) win_q.push_back(32767);
    feed(31, 0, 1'b0);
    release_result();

    // Reset mid-window after 2 of 4 products.
    i_start = 1'b1; i_k_len = 5'd4;
    step();
    i_start = 1'b0; i_mul_vld = 1'b1; i_mul = 16'd5;
    step();
    i_mul = 16'd6;
    step();
    i_mul_vld = 1'b0;
    check_eq("mid_busy", busy24, 1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_acc", acc24, 0);
    check_eq("mid_rst_busy", busy24, 0);
    check_eq("mid_rst_vld", vld24, 0);
    check_eq("mid_rst_ovf", ovf24, 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_mul_vld = 1'b1; i_mul = 16'($urandom); i_acc_rdy = 1'b1;
      step();
      check_eq("post_rst_vld", vld24, 0);
      check_eq("post_rst_busy", busy24, 0);
    end
    i_mul_vld = 1'b0; i_acc_rdy = 1'b0;

    win_q = '{-32768, -32768, -32768};
    feed(3, 0, 1'b0);
    for (int w = 0; w < 24; w++) begin
      k = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 6));
      eff = (k == 0) ? 1 : k;
      mask = int'($urandom & $urandom);
      win_q = {};
      for (int i = 0; i < eff; i++)
        win_q.push_back(($urandom_range(0, 3) == 0) ? 32767 : int'($urandom_range(0, 65535)) - 32768);
      hold(int'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1) begin
        feed(k, mask, 1'b1);
      end else begin
        release_result();
        feed(k, mask, 1'b0);
      end
    end
    release_result();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_acc_unit.md
PE_ACC_UNIT -- requirements
Module: pe_acc_unit

Interface
REQ-001 SHALL have parameter M_BW, default 16, width of the incoming signed product.
REQ-002 SHALL have parameter ACC_BW, default 24, width of the signed accumulator and result.
REQ-003 SHALL have parameter CNT_BW, default 5, width of the window-length field and product counter.
REQ-004 SHALL have port en_clk  input  1  gated clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_start  input  1  pulse: open a new accumulation window.
REQ-007 SHALL have port i_k_len  input  CNT_BW  number of products per window, sampled with i_start.
REQ-008 SHALL have port i_mul_vld  input  1  i_mul holds a valid product this cycle.
REQ-009 SHALL have port i_mul  input  M_BW  signed two's-complement product from the PE multiplier.
REQ-010 SHALL have port i_acc_rdy  input  1  downstream ready for the result.
REQ-011 SHALL have port o_acc_vld  output  1  result valid.
REQ-012 SHALL have port o_acc  output  ACC_BW  signed accumulated result.
REQ-013 SHALL have port o_ovf  output  1  signed overflow occurred in the current or held window.
REQ-014 SHALL have port o_busy  output  1  high in ACCUM state.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, ACCUM, HOLD.
REQ-016 IDLE: on i_start, latch i_k_len, clear accumulator, counter and o_ovf, then go to ACCUM.
REQ-017 SHALL treat a latched i_k_len of 0 as a window length of 1.
REQ-018 ACCUM: on each i_mul_vld, add sign-extended i_mul to the accumulator and increment the counter.
REQ-019 ACCUM: the product that brings the count to the window length moves the FSM to HOLD, with o_acc_vld high the next cycle; latency from last product to o_acc_vld is 1 cycle.
REQ-020 ACCUM: cycles with i_mul_vld low SHALL leave accumulator and counter unchanged.
REQ-021 i_start during ACCUM SHALL be ignored.
REQ-022 i_mul_vld in IDLE or HOLD SHALL be ignored; the product is dropped.
REQ-023 HOLD: o_acc and o_ovf SHALL stay stable while o_acc_vld is high and i_acc_rdy is low.
REQ-024 HOLD: on o_acc_vld && i_acc_rdy, go to IDLE; if i_start is also high that cycle, restart directly into ACCUM per REQ-016 (back-to-back windows, no idle bubble).
REQ-025 SHALL set o_ovf when a signed add overflows ACC_BW; o_ovf SHALL stay set until the next window opens.
REQ-026 o_acc_vld SHALL be high only in HOLD; o_busy SHALL be high only in ACCUM.

Reset
REQ-027 Asserting rst_n low SHALL immediately force IDLE, o_acc=0, o_acc_vld=0, o_ovf=0, o_busy=0, counter=0, latched length=0.
REQ-028 Reset during ACCUM or HOLD SHALL discard the partial or held result; no result SHALL be emitted after release without a new i_start.

Configuration
REQ-029 With macro ACC_SAT_EN defined, an overflowing add SHALL clamp the accumulator to +(2^(ACC_BW-1)-1) or -2^(ACC_BW-1); later adds SHALL proceed from the clamped value.
REQ-030 Without ACC_SAT_EN, an overflowing add SHALL wrap modulo 2^ACC_BW; o_ovf behaves per REQ-025 in both builds.

Verification
REQ-031 i_start with k_len=3, products 100, -20, 5 on consecutive cycles -> o_acc_vld high 1 cycle after the third product, o_acc=85, o_ovf=0.
REQ-032 k_len=4, i_mul_vld gapped (1,0,1,0,1,1), products 7 each -> o_acc=28 only after the fourth valid product; products sent in IDLE and HOLD ignored.
REQ-033 Result held with i_acc_rdy=0 for 5 cycles, then i_acc_rdy=1 and i_start=1 with k_len=1 and product -1 -> o_acc stable for 5 cycles, then the new result -1 is valid exactly 2 cycles after the handshake.
REQ-034 ACC_BW=24, k_len=0, product 32767 -> window length 1, o_acc=32767; i_start during ACCUM leaves window unchanged.
REQ-035 k_len=31, all products 32767 (sum 1015777, fits in 24 bits), and a second run with ACC_BW=16 -> no overflow at ACC_BW=24; at ACC_BW=16, o_ovf=1 and o_acc=32767 with ACC_SAT_EN, wrapped value without it.
REQ-036 rst_n low mid-ACCUM after 2 of 4 products -> all outputs 0 immediately; after release, no o_acc_vld until a new i_start.
